// File: rtl/display_mux_bcd.sv
// Multiplexed active-low 7-segment driver: sequential shift-add-3 binary-to-BCD conversion,
// leading-zero blanking, overflow dashes and round-robin digit scanning.
module display_mux_bcd #(
    parameter int unsigned W_IN     = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [W_IN-1:0]   Frec,
    input  logic              Cargar,
    output logic              Listo,
    output logic              Desborde,
    output logic [7:0]        Seg,
    output logic [DIGITS-1:0] An
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(W_IN + 1);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_shift_en;
    logic               w_commit;

    logic [W_IN-1:0]    r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_disp;
    logic               r_desborde;
    logic               r_listo;

    logic [SCAN_W-1:0]  r_scan;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_seg;
    logic [DIGITS-1:0]  r_an;

    logic [BCD_W-1:0]   w_adj;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic [DIGITS-1:0]  w_blank_vec;
    logic [7:0]         w_seg_nxt;
    logic [DIGITS-1:0]  w_an_nxt;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Cargar) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                w_shift_en = 1'b1;
                if (r_cnt == CNT_W'(1)) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Add-3 correction on every nibble ahead of the shift
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            else                         w_adj[4*i +: 4] = r_bcd[4*i +: 4];
        end
    end

    // Conversion datapath; display registers only change on the commit cycle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_disp     <= '0;
            r_desborde <= 1'b0;
            r_listo    <= 1'b1;
        end else begin
            if (w_load) begin
                r_bin <= Frec;
                r_bcd <= '0;
                r_ovf <= 1'b0;
                r_cnt <= CNT_W'(W_IN);
            end else if (w_shift_en) begin
                r_bin <= r_bin << 1;
                r_bcd <= {w_adj[BCD_W-2:0], r_bin[W_IN-1]};
                r_ovf <= r_ovf | w_adj[BCD_W-1];
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit) begin
                r_disp     <= r_bcd;
                r_desborde <= r_ovf;
            end
            r_listo <= (w_state_nxt == S_IDLE);
        end
    end

    // Scan timer and digit index
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_scan <= r_scan + SCAN_W'(1);
        end
    end

    // Digit select, leading-zero mask and segment lookup
    always_comb begin
        logic zero_above;
        w_nib       = 4'd0;
        w_blank     = 1'b0;
        w_blank_vec = '0;
        w_an_nxt    = '1;
        zero_above  = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above     = zero_above & (r_disp[4*i +: 4] == 4'd0);
            w_blank_vec[i] = zero_above & (i > 0);
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_nib       = r_disp[4*i +: 4];
                w_blank     = w_blank_vec[i];
                w_an_nxt[i] = 1'b0;
            end
        end
        if (r_desborde)                       w_seg_nxt = 8'hBF;
        else if ((BLANK_LZ != 0) && w_blank)  w_seg_nxt = 8'hFF;
        else                                  w_seg_nxt = seg_decode(w_nib);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_seg <= 8'hFF;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign Listo    = r_listo;
    assign Desborde = r_desborde;
    assign Seg      = r_seg;
    assign An       = r_an;

endmodule

// File: tb/tb_display_mux_bcd.sv
// Directed bench for display_mux_bcd: three instances (blanking on, blanking off,
// two digits) share stimulus; expected segment codes are hand-computed.
module tb_display_mux_bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] frec;
    logic       cargar;

    logic       listo_a, desb_a, listo_b, desb_b, listo_c, desb_c;
    logic [7:0] seg_a, seg_b, seg_c;
    logic [2:0] an_a, an_b;
    logic [1:0] an_c;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    display_mux_bcd #(.W_IN(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
        .Clk(clk), .Rst(rst), .Frec(frec), .Cargar(cargar),
        .Listo(listo_a), .Desborde(desb_a), .Seg(seg_a), .An(an_a));

    display_mux_bcd #(.W_IN(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(0)) u_b (
        .Clk(clk), .Rst(rst), .Frec(frec), .Cargar(cargar),
        .Listo(listo_b), .Desborde(desb_b), .Seg(seg_b), .An(an_b));

    display_mux_bcd #(.W_IN(8), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1)) u_c (
        .Clk(clk), .Rst(rst), .Frec(frec), .Cargar(cargar),
        .Listo(listo_c), .Desborde(desb_c), .Seg(seg_c), .An(an_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until digit d of instance inst is enabled, then check its segments
    task automatic digit(input int inst, input int d, input logic [7:0] exp, input string tag);
        logic [7:0] s;
        bit         ok;
        s  = 'x;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            case (inst)
                0:       if (an_a[d] == 1'b0) begin s = seg_a; ok = 1'b1; end
                1:       if (an_b[d] == 1'b0) begin s = seg_b; ok = 1'b1; end
                default: if (an_c[d] == 1'b0) begin s = seg_c; ok = 1'b1; end
            endcase
        end
        chk(tag, {24'd0, s}, {24'd0, exp});
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        frec   = v;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
    endtask

    task automatic wait_listo(output int n);
        n = 0;
        while (!listo_a && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         n;
        logic [2:0] exp_an [3];
        exp_an[0] = 3'b110;
        exp_an[1] = 3'b101;
        exp_an[2] = 3'b011;

        rst    = 1'b1;
        frec   = 8'd0;
        cargar = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_listo", {31'd0, listo_a}, 32'd1);
        chk("rst_desb",  {31'd0, desb_a},  32'd0);
        chk("rst_an",    {29'd0, an_a},    32'h7);
        chk("rst_seg",   {24'd0, seg_a},   32'hFF);
        rst = 1'b0;
        @(negedge clk);
        chk("post_an",  {29'd0, an_a},  32'h6);
        chk("post_seg", {24'd0, seg_a}, 32'hC0);
        digit(0, 1, 8'hFF, "zero_tens_blank");
        digit(0, 2, 8'hFF, "zero_hund_blank");

        // 255: listo low for W_IN+1 cycles, then "255"; two-digit instance overflows
        load(8'd255);
        wait_listo(n);
        chk("busy_cycles_255", 32'(n), 32'd9);
        chk("desb_a_255", {31'd0, desb_a}, 32'd0);
        digit(0, 0, 8'h92, "a255_units");
        digit(0, 1, 8'h92, "a255_tens");
        digit(0, 2, 8'hA4, "a255_hund");
        chk("desb_c_255", {31'd0, desb_c}, 32'd1);
        digit(2, 0, 8'hBF, "c255_units");
        digit(2, 1, 8'hBF, "c255_tens");

        // 7: blanking versus all-digits
        load(8'd7);
        wait_listo(n);
        chk("busy_cycles_7", 32'(n), 32'd9);
        digit(0, 0, 8'hF8, "a7_units");
        digit(0, 1, 8'hFF, "a7_tens");
        digit(0, 2, 8'hFF, "a7_hund");
        digit(1, 1, 8'hC0, "b7_tens");
        digit(1, 2, 8'hC0, "b7_hund");
        chk("desb_c_7", {31'd0, desb_c}, 32'd0);

        // 100: overflow boundary for two digits; interior zeros not blanked on three
        load(8'd100);
        wait_listo(n);
        chk("desb_c_100", {31'd0, desb_c}, 32'd1);
        digit(2, 0, 8'hBF, "c100_units");
        digit(2, 1, 8'hBF, "c100_tens");
        digit(0, 1, 8'hC0, "a100_tens");
        digit(0, 2, 8'hF9, "a100_hund");

        // 99: largest value that fits in two digits
        load(8'd99);
        wait_listo(n);
        chk("desb_c_99", {31'd0, desb_c}, 32'd0);
        digit(2, 0, 8'h90, "c99_units");
        digit(2, 1, 8'h90, "c99_tens");

        // Second load during conversion is ignored
        load(8'd10);
        repeat (2) @(negedge clk);
        frec   = 8'd55;
        cargar = 1'b1;
        @(negedge clk);
        chk("busy_on_reload", {31'd0, listo_a}, 32'd0);
        cargar = 1'b0;
        wait_listo(n);
        repeat (15) @(negedge clk);
        chk("idle_no_queue", {31'd0, listo_a}, 32'd1);
        digit(0, 0, 8'hC0, "a10_units");
        digit(0, 1, 8'hF9, "a10_tens");
        digit(0, 2, 8'hFF, "a10_hund");

        // Scan order, 4 cycles per digit, then wrap
        n = 0;
        while (an_a != 3'b011 && n < 40) begin n++; @(negedge clk); end
        while (an_a != 3'b110 && n < 40) begin n++; @(negedge clk); end
        chk("scan_align", {31'd0, n < 40}, 32'd1);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("scan_%0d", i), {29'd0, an_a}, {29'd0, exp_an[(i / 4) % 3]});
            @(negedge clk);
        end

        // Reset mid-conversion aborts and clears the display
        load(8'd200);
        repeat (2) @(negedge clk);
        chk("conv_busy", {31'd0, listo_a}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_listo", {31'd0, listo_a}, 32'd1);
        chk("abort_an",    {29'd0, an_a},    32'h7);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_an_units", {29'd0, an_a},  32'h6);
        chk("abort_seg_zero", {24'd0, seg_a}, 32'hC0);
        repeat (20) @(negedge clk);
        chk("abort_listo_late", {31'd0, listo_a}, 32'd1);
        chk("abort_desb",       {31'd0, desb_a},  32'd0);
        digit(0, 1, 8'hFF, "abort_tens");
        digit(0, 2, 8'hFF, "abort_hund");
        digit(0, 0, 8'hC0, "abort_units");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
